// File: rtl/dsi_rx_pkg.sv
// Shared types and constants for the D-PHY data-lane receiver.
// FSM state encoding, SoT sync byte, LP pair codes and a near-sync helper.
package dsi_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_STOP      = 3'd1,
      ST_HS_RQST   = 3'd2,
      ST_HS_SYNC   = 3'd3,
      ST_HS_DATA   = 3'd4,
      ST_ESC_WAIT  = 3'd5,
      ST_WAIT_STOP = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // LP pair codes, ordered {p, n}
   localparam logic [1:0] LP_STOP    = 2'b11;
   localparam logic [1:0] LP_HS_RQST = 2'b01;
   localparam logic [1:0] LP_BRIDGE  = 2'b00;
   localparam logic [1:0] LP_LP_RQST = 2'b10;

   // True when b is within Hamming distance 1 of the sync byte (exact included)
   function automatic logic near_sync(input logic [7:0] b);
      logic [7:0] x;
      logic [3:0] ones;
      x    = b ^ SYNC_BYTE;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + {3'b000, x[i]};
      end
      return (ones <= 4'd1);
   endfunction

endpackage

// File: rtl/dsi_lp_filter.sv
// Debounce for the LP line pair: a new pair value is accepted only after it
// has held for LP_FILTER consecutive cycles; shorter glitches are dropped.
module dsi_lp_filter #(
   parameter int LP_FILTER = 2
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic [1:0] lp_raw,
   output logic [1:0] lp_filt
);

   logic [1:0] acc_q, acc_d;
   logic [1:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      acc_d  = acc_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (lp_raw == acc_q) begin
         cnt_d = 4'd0;
      end else begin
         if (lp_raw == cand_q) begin
            cnt_d = cnt_q + 4'd1;
         end else begin
            cand_d = lp_raw;
            cnt_d  = 4'd1;
         end
         if (cnt_d >= 4'(LP_FILTER)) begin
            acc_d = lp_raw;
            cnt_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         acc_q  <= 2'b00;
         cand_q <= 2'b00;
         cnt_q  <= 4'd0;
      end else begin
         acc_q  <= acc_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

   assign lp_filt = acc_q;

endmodule

// File: rtl/dsi_lane_receiver.sv
// Single-lane D-PHY data-lane receiver: LP HS-entry detection, SoT sync search
// at any bit offset, byte-aligned payload. Define DSI_RX_SOT_TOLERANT_EN to accept 1-bit-error sync.
module dsi_lane_receiver
   import dsi_rx_pkg::*;
#(
   parameter int LP_FILTER    = 2,
   parameter int SYNC_TIMEOUT = 64
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] hs_lane_input,
   input  logic       lp_p_input,
   input  logic       lp_n_input,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_sot,
   output logic       out_eot,
   output logic       sot_error,
   output logic       sot_soft_error,
   output logic       active,
   output state_t     state_dbg
);

   localparam int CW = $clog2(SYNC_TIMEOUT + 1);

   logic [1:0]  lp;
   logic [15:0] window;
   state_t      state_q, state_d;
   logic [7:0]  prev_q;
   logic [2:0]  off_q, off_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        first_q, first_d;
   logic        soft_pend_q, soft_pend_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        sot_q, sot_d;
   logic        eot_q, eot_d;
   logic        err_q, err_d;
   logic        soft_q, soft_d;

   logic        exact_hit;
   logic [2:0]  exact_off;
   logic        match_hit;
   logic [2:0]  match_off;
   logic        match_soft;

   dsi_lp_filter #(.LP_FILTER(LP_FILTER)) u_lp_filter (
      .clk_sys (clk_sys),
      .rst     (rst),
      .lp_raw  ({lp_p_input, lp_n_input}),
      .lp_filt (lp)
   );

   assign window = {hs_lane_input, prev_q};

   // Descending scan so the lowest matching offset is the one that sticks
   always_comb begin
      exact_hit = 1'b0;
      exact_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (window[k +: 8] == SYNC_BYTE) begin
            exact_hit = 1'b1;
            exact_off = 3'(k);
         end
      end
   end

`ifdef DSI_RX_SOT_TOLERANT_EN
   logic       near_hit;
   logic [2:0] near_off;

   always_comb begin
      near_hit = 1'b0;
      near_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (near_sync(window[k +: 8])) begin
            near_hit = 1'b1;
            near_off = 3'(k);
         end
      end
   end

   // An exact match anywhere in the window beats a 1-bit match at a lower offset
   assign match_hit  = exact_hit | near_hit;
   assign match_off  = exact_hit ? exact_off : near_off;
   assign match_soft = ~exact_hit & near_hit;
`else
   assign match_hit  = exact_hit;
   assign match_off  = exact_off;
   assign match_soft = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      soft_pend_d = soft_pend_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      sot_d       = 1'b0;
      eot_d       = 1'b0;
      err_d       = 1'b0;
      soft_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lp == LP_STOP) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (lp == LP_HS_RQST)      state_d = ST_HS_RQST;
            else if (lp == LP_LP_RQST) state_d = ST_ESC_WAIT;
         end
         ST_HS_RQST: begin
            if (lp == LP_BRIDGE) begin
               state_d = ST_HS_SYNC;
               cnt_d   = '0;
            end else if (lp == LP_STOP) begin
               state_d = ST_STOP;
            end else if (lp == LP_LP_RQST) begin
               state_d = ST_ESC_WAIT;
            end
         end
         ST_HS_SYNC: begin
            if (lp == LP_STOP) begin
               state_d = ST_STOP;
            end else if (match_hit) begin
               state_d     = ST_HS_DATA;
               off_d       = match_off;
               first_d     = 1'b1;
               soft_pend_d = match_soft;
            end else begin
               if (cnt_q != CW'(SYNC_TIMEOUT)) cnt_d = cnt_q + 1'b1;
               if (cnt_d == CW'(SYNC_TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_STOP;
               end
            end
         end
         ST_HS_DATA: begin
            if (lp == LP_STOP) begin
               eot_d   = 1'b1;
               state_d = ST_STOP;
            end else begin
               valid_d     = 1'b1;
               data_d      = window[off_q +: 8];
               sot_d       = first_q;
               soft_d      = first_q & soft_pend_q;
               first_d     = 1'b0;
               soft_pend_d = 1'b0;
            end
         end
         ST_ESC_WAIT, ST_WAIT_STOP: begin
            if (lp == LP_STOP) state_d = ST_STOP;
         end
         default: state_d = ST_IDLE;
      endcase

      // Receiver disable aborts silently from any state
      if (!enable) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         sot_d   = 1'b0;
         eot_d   = 1'b0;
         err_d   = 1'b0;
         soft_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         prev_q      <= 8'd0;
         off_q       <= 3'd0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         soft_pend_q <= 1'b0;
         data_q      <= 8'd0;
         valid_q     <= 1'b0;
         sot_q       <= 1'b0;
         eot_q       <= 1'b0;
         err_q       <= 1'b0;
         soft_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= hs_lane_input;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         soft_pend_q <= soft_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sot_q       <= sot_d;
         eot_q       <= eot_d;
         err_q       <= err_d;
         soft_q      <= soft_d;
      end
   end

   assign out_data       = data_q;
   assign out_valid      = valid_q;
   assign out_sot        = sot_q;
   assign out_eot        = eot_q;
   assign sot_error      = err_q;
   assign sot_soft_error = soft_q;
   assign active         = (state_q == ST_HS_SYNC) || (state_q == ST_HS_DATA);
   assign state_dbg      = state_q;

endmodule
